seq_unlock_fsm: RTL and testbench

- Parametrised successor to the team's small user-input FSM: a sequence-unlock controller.
- Accepts a stream of user digits under a valid strobe and compares them against a configured code of SEQ_LEN digits.
- Asserts unlocked on a full match; counts failures and enters a timed lockout after MAX_FAILS; every state encoding, including unused codes, has a defined next state.
- Sits between the user-input front end and the access-control logic.

---
 rtl/seq_unlock_pkg.sv | 14 +
 rtl/seq_unlock_if.sv | 24 ++
 rtl/seq_unlock_timer.sv | 18 +
 rtl/seq_unlock_fsm.sv | 92 +++++++++
 tb/tb_seq_unlock_fsm.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seq_unlock_pkg.sv
// seq_unlock_pkg: state encoding and legality check shared by the unlock controller
package seq_unlock_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      ENTRY    = 3'd1,
      UNLOCKED = 3'd2,
      LOCKOUT  = 3'd3,
      FAULT    = 3'd4
   } state_t;
   function automatic logic is_legal(input logic [STATE_W-1:0] s);
      return s <= 3'd4;
   endfunction
endpackage

// File: rtl/seq_unlock_if.sv
// seq_unlock_if: user-digit input, relock request and status outputs of the unlock controller
interface seq_unlock_if #(
   parameter int IN_W = 3,
   parameter int SEQ_LEN = 4,
   parameter int MAX_FAILS = 3
);
   logic [SEQ_LEN*IN_W-1:0] code_in;
   logic in_valid;
   logic [IN_W-1:0] user_input;
   logic relock;
   logic [2:0] out;
   logic unlocked;
   logic lockout;
   logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt;
   logic err_illegal;
   modport master (
      output code_in, in_valid, user_input, relock,
      input out, unlocked, lockout, fail_cnt, err_illegal
   );
   modport slave (
      input code_in, in_valid, user_input, relock,
      output out, unlocked, lockout, fail_cnt, err_illegal
   );
endinterface

// File: rtl/seq_unlock_timer.sv
// seq_unlock_timer: loadable down-counter shared by the entry timeout and the lockout period
module seq_unlock_timer #(
   parameter int W = 6
) (
   input logic clk,
   input logic rst_n,
   input logic load,
   input logic [W-1:0] load_val,
   input logic en,
   output logic zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   assign zero = cnt == '0;
endmodule

// File: rtl/seq_unlock_fsm.sv
// seq_unlock_fsm: digit-sequence unlock controller with failure counting and timed lockout
module seq_unlock_fsm
   import seq_unlock_pkg::*;
#(
   parameter int IN_W = 3,
   parameter int SEQ_LEN = 4,
   parameter int MAX_FAILS = 3,
   parameter int TIMEOUT = 16,
   parameter int LOCKOUT_CYCLES = 64
) (
   input logic clk,
   input logic rst_n,
   seq_unlock_if.slave bus
);
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int XW = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT > LOCKOUT_CYCLES ? TIMEOUT : LOCKOUT_CYCLES);
   state_t state, nxt;
   logic [FW-1:0] fail_cnt, fail_n;
   logic [XW-1:0] idx, idx_n;
   logic [TW-1:0] load_val;
   logic load, tmr_en, tmr_zero, match, last, fail_lock;
   assign match = bus.in_valid && bus.user_input == bus.code_in[int'(idx)*IN_W +: IN_W];
   assign last = int'(idx) == SEQ_LEN - 1;
   assign fail_lock = int'(fail_cnt) + 1 == MAX_FAILS;
   assign tmr_en = state == ENTRY || state == LOCKOUT;
   assign bus.fail_cnt = fail_cnt;
   seq_unlock_timer #(.W(TW)) timer (
      .clk(clk),
      .rst_n(rst_n),
      .load(load),
      .load_val(load_val),
      .en(tmr_en),
      .zero(tmr_zero)
   );
   always_comb begin
      nxt = state;
      fail_n = fail_cnt;
      idx_n = idx;
      load = 1'b0;
      load_val = TW'(TIMEOUT - 1);
      case (state)
         IDLE, ENTRY: begin
            if (bus.relock) begin
               nxt = IDLE;
               idx_n = '0;
            end else if (match && last) begin
               nxt = UNLOCKED;
               fail_n = '0;
               idx_n = '0;
            end else if (match) begin
               nxt = ENTRY;
               idx_n = idx + 1'b1;
               load = 1'b1;
            end else if (bus.in_valid || (state == ENTRY && tmr_zero)) begin
               // wrong digit or idle timeout: count it, or lock out on the final allowed failure
               nxt = fail_lock ? LOCKOUT : IDLE;
               fail_n = fail_lock ? '0 : fail_cnt + 1'b1;
               idx_n = '0;
               load = fail_lock;
               load_val = TW'(LOCKOUT_CYCLES - 1);
            end
         end
         UNLOCKED: nxt = bus.relock ? IDLE : UNLOCKED;
         LOCKOUT: nxt = tmr_zero ? IDLE : LOCKOUT;
         FAULT: begin
            nxt = IDLE;
            fail_n = bus.relock ? fail_cnt : '0;
            idx_n = '0;
         end
         default: nxt = FAULT;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         fail_cnt <= '0;
         idx <= '0;
         bus.out <= '0;
         bus.unlocked <= 1'b0;
         bus.lockout <= 1'b0;
         bus.err_illegal <= 1'b0;
      end else begin
         state <= nxt;
         fail_cnt <= fail_n;
         idx <= idx_n;
         bus.out <= nxt;
         bus.unlocked <= nxt == UNLOCKED;
         bus.lockout <= nxt == LOCKOUT;
         bus.err_illegal <= bus.err_illegal | !is_legal(state);
      end
endmodule

// File: tb/tb_seq_unlock_fsm.sv
// tb_seq_unlock_fsm: directed scoreboard bench for the unlock controller (SEQ_LEN=4 and SEQ_LEN=1 instances)
module tb_seq_unlock_fsm;
   import seq_unlock_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic exp_err = 1'b0;
   typedef struct {
      string tag;
      bit u;
      logic [2:0] st;
      int fc;
   } exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   seq_unlock_if #(.IN_W(3), .SEQ_LEN(4), .MAX_FAILS(3)) bus ();
   seq_unlock_if #(.IN_W(3), .SEQ_LEN(1), .MAX_FAILS(3)) bus1 ();
   seq_unlock_fsm #(.IN_W(3), .SEQ_LEN(4), .MAX_FAILS(3), .TIMEOUT(16), .LOCKOUT_CYCLES(64)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   seq_unlock_fsm #(.IN_W(3), .SEQ_LEN(1), .MAX_FAILS(3), .TIMEOUT(16), .LOCKOUT_CYCLES(64)) dut1 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus1)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic check_out();
      exp_t e;
      logic [2:0] o;
      logic ul, lk, er;
      logic [1:0] fc;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      o = e.u ? bus1.out : bus.out;
      ul = e.u ? bus1.unlocked : bus.unlocked;
      lk = e.u ? bus1.lockout : bus.lockout;
      er = e.u ? bus1.err_illegal : bus.err_illegal;
      fc = e.u ? bus1.fail_cnt : bus.fail_cnt;
      chk({e.tag, ".out"}, 32'(o), 32'(e.st));
      chk({e.tag, ".unlocked"}, 32'(ul), 32'(e.st == 3'd2));
      chk({e.tag, ".lockout"}, 32'(lk), 32'(e.st == 3'd3));
      chk({e.tag, ".fail_cnt"}, 32'(fc), 32'(e.fc));
      chk({e.tag, ".err"}, 32'(er), 32'(e.u ? 1'b0 : exp_err));
   endtask
   task automatic step(input string tag, input bit v, input logic [2:0] d, input bit rl,
                       input logic [2:0] st, input int fc);
      @(negedge clk);
      bus.in_valid = v;
      bus.user_input = d;
      bus.relock = rl;
      sb.push_back('{tag, 1'b0, st, fc});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.relock = 1'b0;
      check_out();
   endtask
   task automatic step1(input string tag, input logic [2:0] d, input logic [2:0] st, input int fc);
      @(negedge clk);
      bus1.in_valid = 1'b1;
      bus1.user_input = d;
      sb.push_back('{tag, 1'b1, st, fc});
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      check_out();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bus.code_in = {3'd2, 3'd7, 3'd1, 3'd4};
      bus.in_valid = 1'b0;
      bus.user_input = '0;
      bus.relock = 1'b0;
      bus1.code_in = 3'd3;
      bus1.in_valid = 1'b0;
      bus1.user_input = '0;
      bus1.relock = 1'b0;
      #12;
      chk("rst.out", 32'(bus.out), 32'd0);
      chk("rst.unlocked", 32'(bus.unlocked), 32'd0);
      chk("rst.lockout", 32'(bus.lockout), 32'd0);
      chk("rst.fail_cnt", 32'(bus.fail_cnt), 32'd0);
      chk("rst.err", 32'(bus.err_illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // full match 4,1,7,2
      step("t1_d0", 1, 3'd4, 0, 3'd1, 0);
      step("t1_d1", 1, 3'd1, 0, 3'd1, 0);
      step("t1_d2", 1, 3'd7, 0, 3'd1, 0);
      step("t1_d3", 1, 3'd2, 0, 3'd2, 0);
      step("t1_relock", 0, 3'd0, 1, 3'd0, 0);
      // three wrong attempts lead to lockout
      step("t2_a0", 1, 3'd4, 0, 3'd1, 0);
      step("t2_a1", 1, 3'd1, 0, 3'd1, 0);
      step("t2_a2", 1, 3'd5, 0, 3'd0, 1);
      step("t2_b0", 1, 3'd4, 0, 3'd1, 1);
      step("t2_b1", 1, 3'd1, 0, 3'd1, 1);
      step("t2_b2", 1, 3'd5, 0, 3'd0, 2);
      step("t2_c0", 1, 3'd4, 0, 3'd1, 2);
      step("t2_c1", 1, 3'd1, 0, 3'd1, 2);
      step("t2_c2", 1, 3'd5, 0, 3'd3, 0);
      for (int i = 0; i < 63; i++) step("t2_hold", 1, 3'd4, 1, 3'd3, 0);
      step("t2_end", 0, 3'd0, 0, 3'd0, 0);
      // entry timeout and last-cycle digit acceptance
      step("t3_d0", 1, 3'd4, 0, 3'd1, 0);
      for (int i = 0; i < 15; i++) step("t3_wait", 0, 3'd0, 0, 3'd1, 0);
      step("t3_timeout", 0, 3'd0, 0, 3'd0, 1);
      step("t3_d0b", 1, 3'd4, 0, 3'd1, 1);
      for (int i = 0; i < 15; i++) step("t3_waitb", 0, 3'd0, 0, 3'd1, 1);
      step("t3_late", 1, 3'd1, 0, 3'd1, 1);
      step("t3_d2", 1, 3'd7, 0, 3'd1, 1);
      step("t3_d3", 1, 3'd2, 0, 3'd2, 0);
      // relock from UNLOCKED and relock beating a matching digit in ENTRY
      step("t4_relock_u", 0, 3'd0, 1, 3'd0, 0);
      step("t4_d0", 1, 3'd4, 0, 3'd1, 0);
      step("t4_relock_e", 1, 3'd1, 1, 3'd0, 0);
      step("t4_idx0", 1, 3'd4, 0, 3'd1, 0);
      step("t4_d1", 1, 3'd1, 0, 3'd1, 0);
      step("t4_miss", 1, 3'd5, 0, 3'd0, 1);
      step("t4_e0", 1, 3'd4, 0, 3'd1, 1);
      step("t4_relock_keep", 1, 3'd1, 1, 3'd0, 1);
      step("t4_u0", 1, 3'd4, 0, 3'd1, 1);
      step("t4_u1", 1, 3'd1, 0, 3'd1, 1);
      step("t4_u2", 1, 3'd7, 0, 3'd1, 1);
      step("t4_u3", 1, 3'd2, 0, 3'd2, 0);
      step("t4_relock_u2", 0, 3'd0, 1, 3'd0, 0);
      // illegal state recovery
      @(negedge clk);
      force dut.state = state_t'(3'd6);
      #1;
      release dut.state;
      exp_err = 1'b1;
      sb.push_back('{"t5_fault", 1'b0, 3'd4, 0});
      @(posedge clk);
      #1;
      check_out();
      step("t5_idle", 0, 3'd0, 0, 3'd0, 0);
      step("t5_sticky", 1, 3'd4, 0, 3'd1, 0);
      step("t5_relock", 0, 3'd0, 1, 3'd0, 0);
      // async reset in the middle of lockout
      step("t6_f0", 1, 3'd5, 0, 3'd0, 1);
      step("t6_f1", 1, 3'd5, 0, 3'd0, 2);
      step("t6_f2", 1, 3'd5, 0, 3'd3, 0);
      for (int i = 0; i < 5; i++) step("t6_hold", 0, 3'd0, 0, 3'd3, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_err = 1'b0;
      chk("t6_rst.out", 32'(bus.out), 32'd0);
      chk("t6_rst.unlocked", 32'(bus.unlocked), 32'd0);
      chk("t6_rst.lockout", 32'(bus.lockout), 32'd0);
      chk("t6_rst.fail_cnt", 32'(bus.fail_cnt), 32'd0);
      chk("t6_rst.err", 32'(bus.err_illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("t6_after", 1, 3'd4, 0, 3'd1, 0);
      // single-digit code instance
      step1("t6_s1_miss", 3'd2, 3'd0, 1);
      step1("t6_s1_hit", 3'd3, 3'd2, 0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
